// File: rtl/rom_load_sequencer.sv
// ROM/PROM download sequencer for the Williams core: decodes hps_io bytes into three
// memory regions and owns core reset. Optional macro ROM_CHECKSUM_EN adds per-region byte sums.
module rom_load_sequencer #(
  parameter logic [15:0] SND_BASE = 16'hC000,
  parameter logic [15:0] DEC_BASE = 16'hD000,
  parameter logic [15:0] DEC_END  = 16'hD3FF,
  parameter int unsigned RST_HOLD = 1024
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        rst_req,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [15:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic [2:0]  mem_we,
  input  logic        mem_busy,
  output logic        core_reset,
  output logic        load_done,
  output logic [7:0]  drop_cnt
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [15:0] sum_main,
  output logic [15:0] sum_snd,
  output logic [15:0] sum_dec
`endif
);

  localparam int unsigned CNT_W = $clog2(RST_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RST_HOLD);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic             dl_q;
  logic             dl_rise;
  logic             dl_fall;
  logic             buf_full;
  logic             retire;
  logic             wr_load;
  logic             accept;
  logic             drop;
  logic [2:0]       dec_we;
  logic [15:0]      dec_addr;

  // Region decode of the incoming byte address into a one-hot enable and local offset
  always_comb begin
    dec_we   = 3'b000;
    dec_addr = 16'h0000;
    if (ioctl_addr < SND_BASE) begin
      dec_we   = 3'b001;
      dec_addr = ioctl_addr;
    end else if (ioctl_addr < DEC_BASE) begin
      dec_we   = 3'b010;
      dec_addr = ioctl_addr - SND_BASE;
    end else if (ioctl_addr <= DEC_END) begin
      dec_we   = 3'b100;
      dec_addr = ioctl_addr - DEC_BASE;
    end
  end

  // The registered write enable doubles as the one-entry buffer's full flag
  assign buf_full   = |mem_we;
  assign retire     = buf_full & ~mem_busy;
  assign ioctl_wait = buf_full & mem_busy;
  assign wr_load    = ioctl_wr & (state == ST_LOAD);
  assign accept     = wr_load & ~ioctl_wait & (|dec_we);
  assign drop       = wr_load & (ioctl_wait | ~(|dec_we));
  assign dl_rise    = ioctl_download & ~dl_q;
  assign dl_fall    = ~ioctl_download & dl_q;

  // Write buffer: capture on accept, hold through busy, clear on retire
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      mem_we   <= 3'b000;
      mem_addr <= 16'h0000;
      mem_data <= 8'h00;
    end else if (accept) begin
      mem_we   <= dec_we;
      mem_addr <= dec_addr;
      mem_data <= ioctl_dout;
    end else if (retire) begin
      mem_we   <= 3'b000;
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      drop_cnt <= 8'h00;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Core reset sequencer; a rising download preempts every state
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state      <= ST_HOLD;
      hold_cnt   <= HOLD_LOAD;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      dl_q       <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      if (dl_rise) begin
        state      <= ST_LOAD;
        core_reset <= 1'b1;
      end else begin
        case (state)
          ST_HOLD: begin
            core_reset <= 1'b1;
            if (rst_req) begin
              hold_cnt <= HOLD_LOAD;
            end else if (hold_cnt <= CNT_W'(1)) begin
              hold_cnt   <= '0;
              state      <= ST_RUN;
              core_reset <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt - CNT_W'(1);
            end
          end
          ST_RUN: begin
            if (rst_req) begin
              hold_cnt   <= HOLD_LOAD;
              state      <= ST_HOLD;
              core_reset <= 1'b1;
            end
          end
          ST_LOAD: begin
            core_reset <= 1'b1;
            if (dl_fall) begin
              state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            core_reset <= 1'b1;
            if (!buf_full) begin
              hold_cnt  <= HOLD_LOAD;
              load_done <= 1'b1;
              state     <= ST_HOLD;
            end
          end
          default: begin
            state      <= ST_HOLD;
            hold_cnt   <= HOLD_LOAD;
            core_reset <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef ROM_CHECKSUM_EN
  // Sums track retired bytes only; a new download restarts them
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      sum_main <= 16'h0000;
      sum_snd  <= 16'h0000;
      sum_dec  <= 16'h0000;
    end else if (dl_rise) begin
      sum_main <= 16'h0000;
      sum_snd  <= 16'h0000;
      sum_dec  <= 16'h0000;
    end else if (retire) begin
      if (mem_we[0]) sum_main <= sum_main + 16'(mem_data);
      if (mem_we[1]) sum_snd  <= sum_snd  + 16'(mem_data);
      if (mem_we[2]) sum_dec  <= sum_dec  + 16'(mem_data);
    end
  end
`endif

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Scoreboard bench for rom_load_sequencer: driver feeds a region/handshake model, monitor checks retires.
module tb_rom_load_sequencer;

  logic        clk_sys = 1'b0;
  logic        RESET;
  logic        rst_req;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [2:0]  mem_we;
  logic        mem_busy;
  logic        core_reset;
  logic        load_done;
  logic [7:0]  drop_cnt;
`ifdef ROM_CHECKSUM_EN
  logic [15:0] sum_main;
  logic [15:0] sum_snd;
  logic [15:0] sum_dec;
`endif

  always #5 clk_sys = ~clk_sys;

  rom_load_sequencer dut (
    .clk_sys        (clk_sys),
    .RESET          (RESET),
    .rst_req        (rst_req),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_we         (mem_we),
    .mem_busy       (mem_busy),
    .core_reset     (core_reset),
    .load_done      (load_done),
    .drop_cnt       (drop_cnt)
`ifdef ROM_CHECKSUM_EN
    ,
    .sum_main       (sum_main),
    .sum_snd        (sum_snd),
    .sum_dec        (sum_dec)
`endif
  );

  typedef struct packed {
    logic [2:0]  we;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  int  n_vec = 0;
  int  n_err = 0;
  wr_t sb_q[$];
  bit  m_full    = 1'b0;
  bit  m_in_load = 1'b0;
  int  m_drop    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int drop_exp();
    return (m_drop > 255) ? 255 : m_drop;
  endfunction

  // Reference memory map
  function automatic bit decode(input logic [15:0] a, output logic [2:0] we, output logic [15:0] la);
    we = 3'b000;
    la = 16'h0000;
    if (a < 16'hC000) begin
      we = 3'b001; la = a; return 1'b1;
    end
    if (a < 16'hD000) begin
      we = 3'b010; la = a - 16'hC000; return 1'b1;
    end
    if (a <= 16'hD3FF) begin
      we = 3'b100; la = a - 16'hD000; return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock of stimulus; the model decides acceptance and the expected wait
  task automatic cyc(input bit wr, input logic [15:0] a, input logic [7:0] d, input bit busy);
    bit          ret;
    bit          wt;
    bit          acc;
    logic [2:0]  we;
    logic [15:0] la;
    @(negedge clk_sys);
    ioctl_wr   = wr;
    ioctl_addr = a;
    ioctl_dout = d;
    mem_busy   = busy;
    ret = m_full && !busy;
    wt  = m_full && !ret;
    acc = 1'b0;
    if (wr && m_in_load) begin
      if (wt) m_drop++;
      else if (decode(a, we, la)) begin
        sb_q.push_back('{we: we, addr: la, data: d});
        acc = 1'b1;
      end else m_drop++;
    end
    m_full = acc || (m_full && !ret);
    #1 chk("ioctl_wait", 32'(ioctl_wait), 32'(wt));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 8'h00, 1'b0);
  endtask

  // Count clock edges until core_reset releases, bounded
  task automatic count_hold(input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk_sys);
      #1;
      n++;
      if (!core_reset) done = 1'b1;
    end
    chk(name, 32'(n), 32'd1024);
  endtask

  task automatic start_download();
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    idle(1);
    m_in_load = 1'b1;
  endtask

  // Monitor: pops an expectation on every retire and checks hold stability under busy
  initial begin
    wr_t prev;
    wr_t exp_w;
    wr_t cur;
    bit  prev_act;
    prev_act = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk_sys);
      #2;
      if (RESET) begin
        prev_act = 1'b0;
        continue;
      end
      cur = '{we: mem_we, addr: mem_addr, data: mem_data};
      if (prev_act) chk("held_under_busy", 32'(cur), 32'(prev));
      prev_act = (mem_we != 3'b000) && mem_busy;
      prev = cur;
      if ((mem_we != 3'b000) && !mem_busy) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got we=%b addr=0x%h data=0x%h expected none at %0t",
                   mem_we, mem_addr, mem_data, $time);
        end else begin
          exp_w = sb_q.pop_front();
          chk("retire", 32'(cur), 32'(exp_w));
        end
      end
    end
  end

  initial begin
    RESET = 1'b1;
    rst_req = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = 16'h0000;
    ioctl_dout = 8'h00;
    mem_busy = 1'b0;
    repeat (3) @(negedge clk_sys);
    #1;
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_data), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    @(negedge clk_sys);
    RESET = 1'b0;
    count_hold("hold_after_reset");
    chk("no_load_done", 32'(load_done), 32'd0);

    // Writes outside a download are ignored and not counted
    cyc(1'b1, 16'h0010, 8'h12, 1'b0);
    cyc(1'b1, 16'hE000, 8'h34, 1'b0);
    idle(2);
    chk("outside_load_drop", 32'(drop_cnt), 32'd0);
    chk("outside_load_we", 32'(mem_we), 32'd0);

    @(negedge clk_sys);
    rst_req = 1'b1;
    idle(5);
    chk("rst_req_core_reset", 32'(core_reset), 32'd1);
    @(negedge clk_sys);
    rst_req = 1'b0;
    count_hold("hold_after_rst_req");

    start_download();
    chk("load_core_reset", 32'(core_reset), 32'd1);

    // Region boundaries, one-cycle latency
    cyc(1'b1, 16'h0005, 8'hA1, 1'b0);
    idle(1);
    chk("lat_main_we", 32'(mem_we), 32'd1);
    chk("lat_main_addr", 32'(mem_addr), 32'h0005);
    cyc(1'b1, 16'hC010, 8'hA2, 1'b0);
    idle(1);
    chk("lat_snd_we", 32'(mem_we), 32'd2);
    chk("lat_snd_addr", 32'(mem_addr), 32'h0010);
    cyc(1'b1, 16'hD3FF, 8'hA3, 1'b0);
    idle(1);
    chk("lat_dec_we", 32'(mem_we), 32'd4);
    chk("lat_dec_addr", 32'(mem_addr), 32'h03FF);
    idle(1);

    // Busy back-pressure with one protocol-violating write, then back-to-back on retire
    cyc(1'b1, 16'h0100, 8'h55, 1'b0);
    cyc(1'b0, 16'h0000, 8'h00, 1'b1);
    cyc(1'b0, 16'h0000, 8'h00, 1'b1);
    cyc(1'b1, 16'h0200, 8'h66, 1'b1);
    cyc(1'b0, 16'h0000, 8'h00, 1'b1);
    cyc(1'b0, 16'h0000, 8'h00, 1'b1);
    cyc(1'b1, 16'hC123, 8'h77, 1'b0);
    idle(1);
    chk("b2b_we", 32'(mem_we), 32'd2);
    chk("b2b_addr", 32'(mem_addr), 32'h0123);
    chk("b2b_data", 32'(mem_data), 32'h77);
    chk("violation_drop", 32'(drop_cnt), 32'd1);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [15:0] a;
      case ($urandom_range(0, 3))
        0: a = 16'($urandom_range(0, 16'hBFFF));
        1: a = 16'($urandom_range(16'hC000, 16'hCFFF));
        2: a = 16'($urandom_range(16'hD000, 16'hD3FF));
        default: a = 16'($urandom);
      endcase
      cyc(1'($urandom_range(0, 1)), a, 8'($urandom), ($urandom_range(0, 9) < 3));
    end
    idle(3);
    chk("rand_drop", 32'(drop_cnt), 32'(drop_exp()));
    chk("rand_sb_empty", 32'(sb_q.size()), 32'd0);

    // Out-of-range saturation
    cyc(1'b1, 16'hD400, 8'h01, 1'b0);
    for (int i = 0; i < 300; i++)
      cyc(1'b1, 16'($urandom_range(16'hD400, 16'hFFFF)), 8'($urandom), 1'b0);
    idle(2);
    chk("drop_saturate", 32'(drop_cnt), 32'd255);

    // Download ends with a write stuck behind busy
    cyc(1'b1, 16'hC001, 8'h99, 1'b0);
    ioctl_download = 1'b0;
    m_in_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 16'h0000, 8'h00, 1'b1);
      chk("drain_no_done", 32'(load_done), 32'd0);
      chk("drain_core_reset", 32'(core_reset), 32'd1);
    end
    cyc(1'b0, 16'h0000, 8'h00, 1'b0);
    idle(1);
    chk("drain_done_late", 32'(load_done), 32'd0);
    idle(1);
    chk("drain_done", 32'(load_done), 32'd1);
    count_hold("hold_after_drain");
    chk("load_done_sticky", 32'(load_done), 32'd1);

    // Reset mid-download loses the in-flight write
    start_download();
    cyc(1'b1, 16'h0040, 8'hEE, 1'b0);
    cyc(1'b0, 16'h0000, 8'h00, 1'b1);
    RESET = 1'b1;
    ioctl_download = 1'b0;
    #1;
    chk("async_we_clear", 32'(mem_we), 32'd0);
    chk("async_load_done", 32'(load_done), 32'd0);
    chk("async_drop", 32'(drop_cnt), 32'd0);
    sb_q.delete();
    m_full = 1'b0;
    m_drop = 0;
    m_in_load = 1'b0;
    @(negedge clk_sys);
    RESET = 1'b0;
    mem_busy = 1'b0;
    idle(2);
    chk("post_reset_core_reset", 32'(core_reset), 32'd1);

`ifdef ROM_CHECKSUM_EN
    start_download();
    cyc(1'b1, 16'hC000, 8'hFF, 1'b0);
    cyc(1'b1, 16'hC001, 8'h02, 1'b0);
    idle(2);
    chk("sum_snd", 32'(sum_snd), 32'h0101);
    chk("sum_main", 32'(sum_main), 32'h0000);
    chk("sum_dec", 32'(sum_dec), 32'h0000);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    m_in_load = 1'b0;
    idle(3);
    start_download();
    chk("sum_snd_clear", 32'(sum_snd), 32'h0000);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    m_in_load = 1'b0;
    idle(3);
`endif

    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
